// File: rtl/rally_referee_pkg.sv
// -----------------------------------------------------------------------------
// rally_referee_pkg
//   Shared tennis definitions used by the ball and the referee: game defaults,
//   the referee state encoding and a saturating score increment helper.
// -----------------------------------------------------------------------------
package rally_referee_pkg;

   // Game defaults
   localparam int unsigned DefWinScore    = 7;
   localparam int unsigned DefMaxSpeedups = 8;

   // Referee state encoding (plain constants for legacy tools)
   localparam logic [2:0] StServe = 3'd0;
   localparam logic [2:0] StRally = 3'd1;
   localparam logic [2:0] StPoint = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StOver  = 3'd4;

   // Increment a score, never passing the limit
   function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
      return (value >= limit) ? limit : value + 4'd1;
   endfunction

endpackage

// File: rtl/rally_referee_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   Rising-edge detector: the input level is registered and rise flags a cycle
//   where the input is high but the registered copy is still low.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-low reset (registered copy loads 0)
//     din  - level input
//     rise - high while din is 1 and was 0 at the previous clock edge
// -----------------------------------------------------------------------------
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         din_q <= 1'b0;
      end else begin
         din_q <= din;
      end
   end

   // Consumed only by registered logic in the referee
   assign rise = din & ~din_q;

endmodule

// File: rtl/rally_referee.sv
// -----------------------------------------------------------------------------
// rally_referee
//   Referee for a two-player rally game. Watches the ball's hit windows and the
//   players' buttons, issues return pulses for valid hits (capped per rally),
//   awards points when a window closes without a hit and tracks the scores.
//   Ports:
//     clk, rst                 - clock, synchronous active-low reset
//     button_one/two           - debounced player buttons
//     hittable_one/two         - ball sits at that player's end
//     start_game               - rally in flight (from the ball)
//     return_one/two           - one-cycle pulse, valid hit sent back to ball
//     match_one/two            - one-cycle pulse, that player wins a point
//     score_one/two            - registered point totals
//     game_over, winner        - game finished / who won (0 = one, 1 = two)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module rally_referee
   import rally_referee_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = DefWinScore,
   parameter int unsigned MAX_SPEEDUPS = DefMaxSpeedups
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_one,
   input  logic       button_two,
   input  logic       hittable_one,
   input  logic       hittable_two,
   input  logic       start_game,
   output logic       return_one,
   output logic       return_two,
   output logic       match_one,
   output logic       match_two,
   output logic [3:0] score_one,
   output logic [3:0] score_two,
   output logic       game_over,
   output logic       winner
);

   localparam int unsigned    CntW     = $clog2(MAX_SPEEDUPS + 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_SPEEDUPS);
   localparam logic [3:0]     WinScore = 4'(WIN_SCORE);

   logic b1_rise, b2_rise;

   rise_detect u_rise_one (
      .clk  (clk),
      .rst  (rst),
      .din  (button_one),
      .rise (b1_rise)
   );

   rise_detect u_rise_two (
      .clk  (clk),
      .rst  (rst),
      .din  (button_two),
      .rise (b2_rise)
   );

   logic [2:0]      state_q, state_d;
   logic            h1_q, h2_q;
   logic            open1_q, open1_d, open2_q, open2_d;
   logic            hit1_q, hit1_d, hit2_q, hit2_d;
   logic            lock1_q, lock1_d, lock2_q, lock2_d;
   logic [CntW-1:0] ret_cnt_q, ret_cnt_d;
   logic            return_one_q, return_one_d, return_two_q, return_two_d;
   logic            match_one_q, match_one_d, match_two_q, match_two_d;
   logic [3:0]      score_one_q, score_one_d, score_two_q, score_two_d;
   logic            game_over_q, game_over_d;
   logic            winner_q, winner_d;
   logic            point_two_q, point_two_d;

   logic in_rally, both;
   logic h1_rise, h1_fall, h2_rise, h2_fall;
   logic win1, win2, hit1, hit2, early1, early2;
   logic close1, close2, miss1, miss2, can_ret;

   always_comb begin
      in_rally = (state_q == StRally);
      // Both ends claiming the ball is nonsense; neither window counts
      both     = hittable_one & hittable_two;
      h1_rise  = hittable_one & ~h1_q;
      h1_fall  = ~hittable_one & h1_q;
      h2_rise  = hittable_two & ~h2_q;
      h2_fall  = ~hittable_two & h2_q;
      // A window counts as open from the cycle its rising edge is seen
      win1     = hittable_one & ~both & (open1_q | h1_rise);
      win2     = hittable_two & ~both & (open2_q | h2_rise);
      hit1     = in_rally & b1_rise & win1 & ~hit1_q & ~lock1_q;
      hit2     = in_rally & b2_rise & win2 & ~hit2_q & ~lock2_q;
      early1   = in_rally & b1_rise & ~hittable_one;
      early2   = in_rally & b2_rise & ~hittable_two;
      close1   = in_rally & open1_q & h1_fall;
      close2   = in_rally & open2_q & h2_fall;
      miss1    = close1 & ~hit1_q;
      miss2    = close2 & ~hit2_q;
      can_ret  = (ret_cnt_q < MaxCnt);
   end

   always_comb begin
      state_d      = state_q;
      open1_d      = open1_q;
      open2_d      = open2_q;
      hit1_d       = hit1_q;
      hit2_d       = hit2_q;
      lock1_d      = lock1_q;
      lock2_d      = lock2_q;
      ret_cnt_d    = ret_cnt_q;
      return_one_d = 1'b0;
      return_two_d = 1'b0;
      match_one_d  = 1'b0;
      match_two_d  = 1'b0;
      score_one_d  = score_one_q;
      score_two_d  = score_two_q;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      point_two_d  = point_two_q;

      case (state_q)
         StServe: begin
            ret_cnt_d = '0;
            open1_d   = 1'b0;
            open2_d   = 1'b0;
            hit1_d    = 1'b0;
            hit2_d    = 1'b0;
            if (start_game) state_d = StRally;
         end

         StRally: begin
            if (both)         open1_d = 1'b0;
            else if (h1_rise) open1_d = 1'b1;
            else if (h1_fall) open1_d = 1'b0;
            if (both)         open2_d = 1'b0;
            else if (h2_rise) open2_d = 1'b1;
            else if (h2_fall) open2_d = 1'b0;

            // Hit flag belongs to one window: cleared when a window opens or closes
            if (h1_rise || close1) hit1_d = 1'b0;
            if (hit1)              hit1_d = 1'b1;
            if (h2_rise || close2) hit2_d = 1'b0;
            if (hit2)              hit2_d = 1'b1;

            // An early swing also locks the next window, so set beats clear
            if (close1) lock1_d = 1'b0;
            if (early1) lock1_d = 1'b1;
            if (close2) lock2_d = 1'b0;
            if (early2) lock2_d = 1'b1;

            // Windows never overlap, so at most one hit per cycle
            if ((hit1 || hit2) && can_ret) begin
               return_one_d = hit1;
               return_two_d = hit2;
               ret_cnt_d    = ret_cnt_q + CntW'(1);
            end

            if (miss1) begin
               score_two_d = sat_inc(score_two_q, WinScore);
               match_two_d = 1'b1;
               point_two_d = 1'b1;
               state_d     = StPoint;
            end else if (miss2) begin
               score_one_d = sat_inc(score_one_q, WinScore);
               match_one_d = 1'b1;
               point_two_d = 1'b0;
               state_d     = StPoint;
            end
         end

         StPoint: begin
            open1_d = 1'b0;
            open2_d = 1'b0;
            hit1_d  = 1'b0;
            hit2_d  = 1'b0;
            if ((point_two_q ? score_two_q : score_one_q) == WinScore) begin
               game_over_d = 1'b1;
               winner_d    = point_two_q;
               state_d     = StOver;
            end else begin
               state_d = StDrain;
            end
         end

         StDrain: begin
            open1_d = 1'b0;
            open2_d = 1'b0;
            hit1_d  = 1'b0;
            hit2_d  = 1'b0;
            if (!start_game) state_d = StServe;
         end

         StOver: begin
            if (button_one && button_two) begin
               score_one_d = 4'd0;
               score_two_d = 4'd0;
               game_over_d = 1'b0;
               lock1_d     = 1'b0;
               lock2_d     = 1'b0;
               state_d     = StDrain;
            end
         end

         default: state_d = StServe;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StServe;
         h1_q         <= 1'b0;
         h2_q         <= 1'b0;
         open1_q      <= 1'b0;
         open2_q      <= 1'b0;
         hit1_q       <= 1'b0;
         hit2_q       <= 1'b0;
         lock1_q      <= 1'b0;
         lock2_q      <= 1'b0;
         ret_cnt_q    <= '0;
         return_one_q <= 1'b0;
         return_two_q <= 1'b0;
         match_one_q  <= 1'b0;
         match_two_q  <= 1'b0;
         score_one_q  <= 4'd0;
         score_two_q  <= 4'd0;
         game_over_q  <= 1'b0;
         winner_q     <= 1'b0;
         point_two_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         h1_q         <= hittable_one;
         h2_q         <= hittable_two;
         open1_q      <= open1_d;
         open2_q      <= open2_d;
         hit1_q       <= hit1_d;
         hit2_q       <= hit2_d;
         lock1_q      <= lock1_d;
         lock2_q      <= lock2_d;
         ret_cnt_q    <= ret_cnt_d;
         return_one_q <= return_one_d;
         return_two_q <= return_two_d;
         match_one_q  <= match_one_d;
         match_two_q  <= match_two_d;
         score_one_q  <= score_one_d;
         score_two_q  <= score_two_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         point_two_q  <= point_two_d;
      end
   end

   assign return_one = return_one_q;
   assign return_two = return_two_q;
   assign match_one  = match_one_q;
   assign match_two  = match_two_q;
   assign score_one  = score_one_q;
   assign score_two  = score_two_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;

endmodule

// File: doc/rally_referee.md
RALLY_REFEREE -- requirements
Module: rally_referee

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points needed to win a game (range 1..15).
REQ-002 SHALL have parameter MAX_SPEEDUPS, default 8: maximum return pulses issued per rally.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port button_one, input, 1 bit: player-one button, debounced level.
REQ-006 SHALL have port button_two, input, 1 bit: player-two button, debounced level.
REQ-007 SHALL have port hittable_one, input, 1 bit: from the ball, high while the ball sits at player one's end.
REQ-008 SHALL have port hittable_two, input, 1 bit: from the ball, high while the ball sits at player two's end.
REQ-009 SHALL have port start_game, input, 1 bit: from the ball, high while a rally is in flight.
REQ-010 SHALL have port return_one, output, 1 bit: one-cycle pulse to the ball for a valid player-one hit.
REQ-011 SHALL have port return_two, output, 1 bit: one-cycle pulse to the ball for a valid player-two hit.
REQ-012 SHALL have port match_one, output, 1 bit: one-cycle pulse when player one wins a point.
REQ-013 SHALL have port match_two, output, 1 bit: one-cycle pulse when player two wins a point.
REQ-014 SHALL have ports score_one and score_two, outputs, 4 bits each: the registered point totals.
REQ-015 SHALL have port game_over, output, 1 bit: high once a player reaches WIN_SCORE.
REQ-016 SHALL have port winner, output, 1 bit: 0 = player one, 1 = player two; valid only while game_over is high.

Function
REQ-017 SHALL register every output; none SHALL be combinational from an input.
REQ-018 SHALL use the states SERVE, RALLY, POINT, DRAIN and OVER.
REQ-019 SERVE -> RALLY when start_game is 1.
REQ-020 RALLY -> POINT when a hit window closes without a recorded hit (REQ-023).
REQ-021 POINT SHALL last exactly one cycle and pulse the match output of the scoring player.
  - POINT -> OVER if the new score equals WIN_SCORE.
  - POINT -> DRAIN otherwise.
REQ-022 DRAIN -> SERVE when start_game is 0.
REQ-023 The window for side X SHALL open on a rising edge of hittable_X and close on its falling edge.
  - Window-close detection compares against a registered copy of hittable_X.
REQ-024 Hit condition, in RALLY only: a rising edge of button_X while hittable_X is 1, window open, no hit yet recorded in that window, and side X not locked out.
  - Effect: record the hit; pulse return_X 1 cycle later.
REQ-025 A rising edge of button_X in RALLY while hittable_X is 0 SHALL lock out side X until the close of its next window, so a missed early swing cannot be retried.
REQ-026 The return pulse SHALL be issued only while the per-rally return count is below MAX_SPEEDUPS.
  - The return count increments on each issued pulse and clears on entry to SERVE.
  - Hits beyond the cap still count as hits but issue no pulse, protecting the ball's speed counter from underflow.
REQ-027 A window closing without a recorded hit SHALL award the point to the opposite player.
REQ-028 Only one window can be active per cycle; if hittable_one and hittable_two are both 1, both windows SHALL be ignored.
REQ-029 Score registers SHALL saturate at WIN_SCORE.
REQ-030 All button edges in SERVE and DRAIN SHALL be ignored; only the ball's start_game starts the rally.
REQ-031 In OVER:
  - return and match outputs SHALL stay 0;
  - game_over SHALL be 1 and winner SHALL be held;
  - a cycle with button_one and button_two both 1 SHALL clear the scores, game_over and the lockouts, and go to DRAIN.

Reset
REQ-032 When rst=0 at a clock edge, the block SHALL go to SERVE with all outputs, scores, lockouts, hit flags and the return count at 0.
REQ-033 Registered copies of the button and hittable inputs SHALL load 0 on reset, so a level already high at reset release does not count as an edge.
REQ-034 Reset asserted mid-rally or mid-POINT SHALL discard any pending pulse.

Structure
REQ-035 The state encoding, WIN_SCORE and MAX_SPEEDUPS defaults SHALL live in a shared tennis package/include used by the ball and the top level.
REQ-036 The design SHALL instantiate a sub-module rise_detect twice, once per button: a registered rising-edge detector with synchronous active-low reset.

Verification
REQ-037 Scenario: start_game rises, hittable_two rises, button_two rises 3 cycles later -> one return_two pulse, no match pulse, scores unchanged.
REQ-038 Scenario: hittable_one is high for 5 cycles with no press -> match_two pulses once, the cycle after the falling edge, and score_two becomes 1.
REQ-039 Scenario: button_one pressed while hittable_one=0, then pressed again inside the next window -> no return_one; match_two at window close.
REQ-040 Scenario: 10 consecutive valid hits with MAX_SPEEDUPS=8 -> exactly 8 return pulses and no point awarded.
REQ-041 Scenario: score_one=6 and a player-two miss -> match_one pulses, score_one=7, game_over=1, winner=0; further presses give no pulses; both buttons high -> scores 0, game_over 0.
REQ-042 Scenario: rst=0 during an open window with a press in the same cycle -> no return pulse, state SERVE, scores 0 next cycle.
